// File: rtl/keypad_pkg.sv
// Shared types and default timing constants for the keypad scan/debounce controller.
package keypad_pkg;

  localparam int SCAN_DIV_DEFAULT  = 24000;
  localparam int SYNCH_MAX_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_SYNCH    = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_CHECK    = 3'd3,
    S_SEND     = 3'd4,
    S_HOLD     = 3'd5,
    S_RELEASE  = 3'd6
  } state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Mod-SCAN_DIV column-step prescaler; tc flags the last count of each step period.
module scan_prescaler
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/keypad_ctrl_fsm.sv
// Control FSM sequencing keypad scan, synchroniser capture, debounce, confirm and
// single-shot display commit; repeats are blocked until the release is debounced.
module keypad_ctrl_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int SYNCH_MAX = SYNCH_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttonpush,
  input  logic       synch_done,
  input  logic       debounce_done,
  input  logic       post_debounce,
  output logic       scan_counter_en,
  output logic       WE_synch,
  output logic       debounce_counter_en,
  output logic       check_again,
  output logic       WE_send,
  output logic       key_held,
  output logic [2:0] state_dbg
);

  localparam int TW = $clog2(SYNCH_MAX);
  localparam logic [TW-1:0] SYNCH_LAST = TW'(SYNCH_MAX - 1);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] synch_timer;
  logic          presc_tc;

  // Prescaler only runs while scanning and restarts from zero on every re-entry.
  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (state != S_SCAN),
    .en   (state == S_SCAN),
    .tc   (presc_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_SCAN;
      synch_timer <= '0;
    end else begin
      state       <= next_state;
      synch_timer <= (state == S_SYNCH) ? synch_timer + 1'b1 : '0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state          = state;
    scan_counter_en     = 1'b0;
    WE_synch            = 1'b0;
    debounce_counter_en = 1'b0;
    check_again         = 1'b0;
    WE_send             = 1'b0;
    key_held            = 1'b0;
    state_dbg           = state;

    unique case (state)
      S_SCAN: begin
        // A press wins over a column step landing in the same cycle.
        scan_counter_en = presc_tc & ~buttonpush;
        if (buttonpush) next_state = S_SYNCH;
      end
      S_SYNCH: begin
        WE_synch = 1'b1;
        if (!buttonpush)                 next_state = S_SCAN;
        else if (synch_done)             next_state = S_DEBOUNCE;
        else if (synch_timer == SYNCH_LAST) next_state = S_SCAN;
      end
      S_DEBOUNCE: begin
        debounce_counter_en = 1'b1;
        if (debounce_done) next_state = S_CHECK;
      end
      S_CHECK: begin
        check_again = 1'b1;
        next_state  = post_debounce ? S_SEND : S_SCAN;
      end
      S_SEND: begin
        WE_send    = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        key_held = 1'b1;
        if (!buttonpush) next_state = S_RELEASE;
      end
      S_RELEASE: begin
        // A re-press drops the enable, which clears the debounce count.
        key_held            = 1'b1;
        debounce_counter_en = 1'b1;
        if (buttonpush)         next_state = S_HOLD;
        else if (debounce_done) next_state = S_SCAN;
      end
      default: begin
        next_state = S_SCAN;
        state_dbg  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_ctrl_fsm.sv
// Self-checking bench for keypad_ctrl_fsm: directed scenarios with literal
// expectations, then randomized inputs compared each cycle against a phase/age model.
module tb_keypad_ctrl_fsm;

  localparam int DIV  = 4;
  localparam int SMAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       buttonpush;
  logic       synch_done;
  logic       debounce_done;
  logic       post_debounce;
  logic       scan_counter_en;
  logic       WE_synch;
  logic       debounce_counter_en;
  logic       check_again;
  logic       WE_send;
  logic       key_held;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase (numbered as the state_dbg encoding) plus
  // the number of cycles spent in the scanning and synchronising phases.
  int phase    = 0;
  int scan_age = 0;
  int sync_age = 0;

  // Observations: {scan, WE_synch, deb_en, check, WE_send, held, state[2:0]}
  logic [8:0] obs;
  int we_send_seen = 0;
  int scan_seen    = 0;

  always #5 clk = ~clk;

  keypad_ctrl_fsm #(
    .SCAN_DIV (DIV),
    .SYNCH_MAX(SMAX)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .buttonpush         (buttonpush),
    .synch_done         (synch_done),
    .debounce_done      (debounce_done),
    .post_debounce      (post_debounce),
    .scan_counter_en    (scan_counter_en),
    .WE_synch           (WE_synch),
    .debounce_counter_en(debounce_counter_en),
    .check_again        (check_again),
    .WE_send            (WE_send),
    .key_held           (key_held),
    .state_dbg          (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic enter_scan();
    phase    = 0;
    scan_age = 0;
  endtask

  function automatic logic [8:0] expected_out(input logic bp);
    logic [8:0] v;
    v[8]   = (phase == 0) && ((scan_age % DIV) == DIV - 1) && !bp;
    v[7]   = (phase == 1);
    v[6]   = (phase == 2) || (phase == 6);
    v[5]   = (phase == 3);
    v[4]   = (phase == 4);
    v[3]   = (phase == 5) || (phase == 6);
    v[2:0] = 3'(phase);
    return v;
  endfunction

  task automatic model_step(input logic bp, input logic sd, input logic dd, input logic pd);
    case (phase)
      0: if (bp) begin phase = 1; sync_age = 0; end else scan_age++;
      1: begin
        sync_age++;
        if (!bp)                   enter_scan();
        else if (sd)               phase = 2;
        else if (sync_age >= SMAX) enter_scan();
      end
      2: if (dd) phase = 3;
      3: if (pd) phase = 4; else enter_scan();
      4: phase = 5;
      5: if (!bp) phase = 6;
      6: if (bp) phase = 5; else if (dd) enter_scan();
      default: enter_scan();
    endcase
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance model at posedge.
  task automatic cycle(input logic r, input logic bp, input logic sd, input logic dd, input logic pd);
    @(negedge clk);
    reset         = r;
    buttonpush    = bp;
    synch_done    = sd;
    debounce_done = dd;
    post_debounce = pd;
    if (r) enter_scan();
    #1;
    obs = {scan_counter_en, WE_synch, debounce_counter_en, check_again,
           WE_send, key_held, state_dbg};
    check("outputs", 32'(obs), r ? 32'h0 : 32'(expected_out(bp)));
    we_send_seen += int'(WE_send);
    scan_seen    += int'(scan_counter_en);
    @(posedge clk);
    if (!r) model_step(bp, sd, dd, pd);
  endtask

  initial begin
    int  first_ws;
    int  first_scan;
    logic bp_r;

    reset = 1'b1; buttonpush = 1'b0; synch_done = 1'b0;
    debounce_done = 1'b0; post_debounce = 1'b0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("reset_state", 32'(obs), 32'h0);

    // Idle scanning: a column step every 4th cycle, first on the 4th cycle
    scan_seen = 0; first_scan = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (obs[8] && first_scan < 0) first_scan = i;
    end
    check("idle_scan_pulses", 32'(scan_seen), 32'd2);
    check("idle_first_pulse", 32'(first_scan), 32'd3);

    // Clean press: synch_done on 2nd SYNCH cycle, debounce_done on 10th DEBOUNCE cycle
    scan_seen = 0; we_send_seen = 0; first_ws = -1;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, i == 2, i == 12, 1);
      if (obs[4] && first_ws < 0) first_ws = i;
    end
    // press cycle = 0, so WE_send is committed on the 15th edge
    check("press_to_send", 32'(first_ws), 32'd14);
    check("held_after_send", 32'(obs[3]), 32'd1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 1);
    check("one_send_long_hold", 32'(we_send_seen), 32'd1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, i == 3, 0);
    check("scan_quiet_while_held", 32'(scan_seen), 32'd0);
    check("release_back_to_scan", 32'(obs[2:0]), 32'd0);

    // Bounce during synchronisation; glitch beats synch_done
    we_send_seen = 0;
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    scan_seen = 0;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    check("glitch_scan_resumes", 32'(scan_seen), 32'd1);
    check("glitch_no_send", 32'(we_send_seen), 32'd0);

    // Failed confirm
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check("confirm_strobe", 32'(obs[5]), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("confirm_fail_scan", 32'(obs[2:0]), 32'd0);
    check("confirm_fail_no_send", 32'(we_send_seen), 32'd0);

    // Release bounce: re-press in RELEASE returns to HOLD without a second commit
    for (int i = 0; i < 5; i++) cycle(0, 1, i == 1, i == 2, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("rebounce_hold", 32'(obs[2:0]), 32'd5);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("rebounce_release_scan", 32'(obs[2:0]), 32'd0);
    check("rebounce_one_send", 32'(we_send_seen), 32'd1);

    // Asynchronous reset in the middle of a debounce window
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("pre_reset_debounce", 32'(obs[6]), 32'd1);
    cycle(1, 1, 0, 0, 0);
    check("reset_mid_window", 32'(obs), 32'h0);
    cycle(1, 0, 0, 0, 0);

    // Synchroniser abort after 8 cycles without synch_done
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (i == 8) check("abort_last_synch", 32'(obs[2:0]), 32'd1);
      if (i == 9) check("abort_to_scan", 32'(obs[2:0]), 32'd0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

    // Randomized traffic against the model
    bp_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) bp_r = ~bp_r;
      cycle($urandom_range(399) == 0, bp_r, $urandom_range(2) == 0,
            $urandom_range(4) == 0, $urandom_range(3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
